// File: rtl/bram_clear_sequencer_pkg.sv
// rtl/bram_clear_sequencer_pkg.sv - shared types and constants for the BRAM clear sequencer
// Holds the sweep state enum, byte-lane helpers and GPIO bit positions used when wiring instances.
package bram_clear_sequencer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clear_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BYTE_LANES         = DEFAULT_DATA_WIDTH / 8;

  // GPIO bit positions: requests into the sequencers, busy status back out
  localparam int GPIO_PARAM_RESET_BIT = 'h11;
  localparam int GPIO_GRAD_RESET_BIT  = 'h12;
  localparam int GPIO_PARAM_BUSY_BIT  = 'h14;
  localparam int GPIO_GRAD_BUSY_BIT   = 'h15;

  function automatic int byte_lanes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/bram_clear_sequencer_sync_rise_detect.sv
// rtl/bram_clear_sequencer_sync_rise_detect.sv - level synchroniser with one-cycle rising-edge strobe
// Reusable for any quasi-static GPIO request; o_start depends only on flops.
module sync_rise_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_start
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_valid;
  logic                   r_prev;
  logic                   r_armed;

  // r_armed: an edge only counts once a genuine low has left the chain,
  // so a level already high at reset release never fires.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_valid <= '0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_level};
      r_valid <= {r_valid[SYNC_STAGES-2:0], 1'b1};
      r_prev  <= r_sync[SYNC_STAGES-1];
      if (r_valid[SYNC_STAGES-1] && !r_sync[SYNC_STAGES-1]) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_start = r_sync[SYNC_STAGES-1] & ~r_prev & r_armed;

endmodule

// File: rtl/bram_clear_sequencer.sv
// rtl/bram_clear_sequencer.sv - sweeps a BRAM port writing a fill word to every address on request
// Optional BRAM_CLEAR_FILL_EN adds a fill_value port sampled at sweep start; otherwise fills with zero.
module bram_clear_sequencer
  import bram_clear_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    clear_req,
`ifdef BRAM_CLEAR_FILL_EN
  input  logic [DATA_WIDTH-1:0]   fill_value,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    bram_en,
  output logic [DATA_WIDTH/8-1:0] bram_we,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_din
);

  localparam int                    LANES     = byte_lanes(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  clear_state_e          r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_din, w_din_nxt;
  logic                  r_done, w_done_nxt;
  logic                  w_start;
  logic [DATA_WIDTH-1:0] w_fill;

  sync_rise_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_rise_detect (
    .i_clk   (ap_clk),
    .i_rst_n (ap_rst_n),
    .i_level (clear_req),
    .o_start (w_start)
  );

`ifdef BRAM_CLEAR_FILL_EN
  assign w_fill = fill_value;
`else
  assign w_fill = '0;
`endif

  // Counter returns to 0 on exit so the idle address is 0; terminal compare avoids wrap at full depth.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_din_nxt   = r_din;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = CLEAR;
          w_addr_nxt  = '0;
          w_din_nxt   = w_fill;
        end
      end
      CLEAR: begin
        if (r_addr == LAST_ADDR) begin
          w_state_nxt = IDLE;
          w_addr_nxt  = '0;
          w_din_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_addr_nxt = r_addr + ADDR_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_addr_nxt  = '0;
        w_din_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_din   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_din   <= w_din_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign busy      = (r_state == CLEAR);
  assign done      = r_done;
  assign bram_en   = busy;
  assign bram_we   = {LANES{busy}};
  assign bram_addr = r_addr;
  assign bram_din  = r_din;

endmodule

// File: tb/tb_bram_clear_sequencer.sv
// tb/tb_bram_clear_sequencer.sv - self-checking bench for bram_clear_sequencer (DEPTH 16, 1024 and 1)
// Build with BRAM_CLEAR_FILL_EN defined to exercise the fill_value port.
module tb_bram_clear_sequencer;

  localparam int ND       = 3;
  localparam int S        = 2;
  localparam int NO_SWEEP = -100000;
`ifdef BRAM_CLEAR_FILL_EN
  localparam logic [31:0] FILL_EXP = 32'hDEADBEEF;
`else
  localparam logic [31:0] FILL_EXP = 32'h0;
`endif

  logic ap_clk    = 1'b0;
  logic ap_rst_n  = 1'b0;
  logic clear_req = 1'b0;
`ifdef BRAM_CLEAR_FILL_EN
  logic [31:0] fill_value = 32'h0;
`endif

  logic        b16, d16, e16;
  logic [3:0]  w16;
  logic [3:0]  a16;
  logic [31:0] q16;
  logic        b1k, d1k, e1k;
  logic [3:0]  w1k;
  logic [9:0]  a1k;
  logic [31:0] q1k;
  logic        b1, d1, e1;
  logic [3:0]  w1;
  logic [0:0]  a1;
  logic [31:0] q1;

  always #5 ap_clk = ~ap_clk;

  bram_clear_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(16), .SYNC_STAGES(S)) u_dut16 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clear_req(clear_req),
`ifdef BRAM_CLEAR_FILL_EN
    .fill_value(fill_value),
`endif
    .busy(b16), .done(d16), .bram_en(e16), .bram_we(w16), .bram_addr(a16), .bram_din(q16)
  );

  bram_clear_sequencer #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(1024), .SYNC_STAGES(S)) u_dut1k (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clear_req(clear_req),
`ifdef BRAM_CLEAR_FILL_EN
    .fill_value(fill_value),
`endif
    .busy(b1k), .done(d1k), .bram_en(e1k), .bram_we(w1k), .bram_addr(a1k), .bram_din(q1k)
  );

  bram_clear_sequencer #(.ADDR_WIDTH(1), .DATA_WIDTH(32), .DEPTH(1), .SYNC_STAGES(S)) u_dut1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clear_req(clear_req),
`ifdef BRAM_CLEAR_FILL_EN
    .fill_value(fill_value),
`endif
    .busy(b1), .done(d1), .bram_en(e1), .bram_we(w1), .bram_addr(a1), .bram_din(q1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: samples of clear_req since reset, plus the edge at which each DUT's sweep began.
  bit          hist[$];
  int          ts[ND]        = '{default: NO_SWEEP};
  logic [31:0] fexp[ND]      = '{default: 32'h0};
  int          ecnt          = 0;
  int          wcnt[ND]      = '{default: 0};
  int          dcnt[ND]      = '{default: 0};
  int          run[ND]       = '{default: 0};
  int          last_run[ND]  = '{default: 0};
  int          rise_edge[ND] = '{default: 0};
  int          last_addr[ND] = '{default: 0};
  logic [31:0] mem[ND][1024];
  int          wr_edge[ND][1024];

  function automatic int dep(input int d);
    case (d)
      0:       return 16;
      1:       return 1024;
      default: return 1;
    endcase
  endfunction

  // A start is seen after edge u when the synchronised level went from a genuine low to high.
  function automatic bit start_at(input int u);
    if (u < S) return 1'b0;
    return hist[u-S+1] && !hist[u-S];
  endfunction

  function automatic bit in_sweep(input int d, input int u);
    return (u >= ts[d]) && (u <= ts[d] + dep(d) - 1);
  endfunction

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h at edge %0d", nm, d, act, exp, ecnt);
    end
  endtask

  task automatic get_obs(input int d, output logic ob, output logic odn, output logic oe,
                         output logic [3:0] ow, output logic [31:0] oa, output logic [31:0] od);
    case (d)
      0:       begin ob = b16; odn = d16; oe = e16; ow = w16; oa = 32'(a16); od = q16; end
      1:       begin ob = b1k; odn = d1k; oe = e1k; ow = w1k; oa = 32'(a1k); od = q1k; end
      default: begin ob = b1;  odn = d1;  oe = e1;  ow = w1;  oa = 32'(a1);  od = q1;  end
    endcase
  endtask

  initial begin : monitor
    bit          smp, rstv, eb, ed;
    int          t;
    logic [31:0] fv, ea, edin;
    logic        ob, odn, oe;
    logic [3:0]  ow;
    logic [31:0] oa, od;
    forever begin
      @(posedge ap_clk);
      smp  = clear_req;
      rstv = ap_rst_n;
`ifdef BRAM_CLEAR_FILL_EN
      fv = fill_value;
`else
      fv = 32'h0;
`endif
      ecnt++;
      t = -1;
      if (!rstv) begin
        hist.delete();
        for (int d = 0; d < ND; d++) ts[d] = NO_SWEEP;
      end else begin
        hist.push_back(smp);
        t = hist.size() - 1;
        for (int d = 0; d < ND; d++) begin
          if (start_at(t - 1) && !in_sweep(d, t - 1)) begin
            ts[d]   = t;
            fexp[d] = fv;
          end
        end
      end
      #1;
      for (int d = 0; d < ND; d++) begin
        get_obs(d, ob, odn, oe, ow, oa, od);
        eb   = rstv && in_sweep(d, t);
        ed   = rstv && (t == ts[d] + dep(d));
        ea   = eb ? 32'(t - ts[d]) : 32'h0;
        edin = eb ? fexp[d] : 32'h0;
        chk("busy", d, 64'(ob), 64'(eb));
        chk("done", d, 64'(odn), 64'(ed));
        chk("bram_en", d, 64'(oe), 64'(eb));
        chk("bram_we", d, 64'(ow), eb ? 64'hF : 64'h0);
        chk("bram_addr", d, 64'(oa), 64'(ea));
        chk("bram_din", d, 64'(od), 64'(edin));
        if (rstv && ob === 1'b1) begin
          if (run[d] == 0) rise_edge[d] = ecnt;
          run[d]++;
        end else begin
          if (rstv && run[d] > 0) last_run[d] = run[d];
          run[d] = 0;
        end
        if (oe === 1'b1 && ow === 4'hF && oa < 1024) begin
          wcnt[d]++;
          mem[d][oa]     = od;
          wr_edge[d][oa] = ecnt;
          last_addr[d]   = int'(oa);
        end
        if (odn === 1'b1) dcnt[d]++;
      end
    end
  end

  task automatic drive(input int e, input logic v);
    while (ecnt < e - 1) @(negedge ap_clk);
    clear_req = v;
  endtask

  task automatic wait_neg(input int e);
    while (ecnt < e) @(negedge ap_clk);
  endtask

  task automatic chk_zero_all(input string nm);
    logic        ob, odn, oe;
    logic [3:0]  ow;
    logic [31:0] oa, od;
    for (int d = 0; d < ND; d++) begin
      get_obs(d, ob, odn, oe, ow, oa, od);
      chk(nm, d, {22'h0, ob, odn, oe, ow, oa[4:0], od}, 64'h0);
    end
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: bench did not reach its summary, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    int k, bw[ND], bd[ND];
    repeat (3) @(negedge ap_clk);
    chk_zero_all("reset_outputs");
    ap_rst_n = 1'b1;
    repeat (5) @(negedge ap_clk);

    // Raise and hold: one sweep, no retrigger while level stays high.
    k = ecnt + 2;
    for (int d = 0; d < ND; d++) begin bw[d] = wcnt[d]; bd[d] = dcnt[d]; end
    drive(k, 1'b1);
    wait_neg(k + 40);
    chk("first_busy_latency", 0, 64'(rise_edge[0] - k), 64'd2);
    chk("sweep_writes", 0, 64'(wcnt[0] - bw[0]), 64'd16);
    chk("sweep_busy_len", 0, 64'(last_run[0]), 64'd16);
    chk("sweep_done_pulses", 0, 64'(dcnt[0] - bd[0]), 64'd1);
    chk("sweep_last_addr", 0, 64'(last_addr[0]), 64'd15);
    chk("depth1_writes", 2, 64'(wcnt[2] - bw[2]), 64'd1);
    chk("depth1_busy_len", 2, 64'(last_run[2]), 64'd1);
    chk("depth1_latency", 2, 64'(rise_edge[2] - k), 64'd2);

    // Low-high toggle while the sweep is at address 5 is ignored.
    drive(ecnt + 2, 1'b0);
    repeat (5) @(negedge ap_clk);
    k = ecnt + 3;
    for (int d = 0; d < ND; d++) begin bw[d] = wcnt[d]; bd[d] = dcnt[d]; end
    drive(k, 1'b1);
    drive(k + 6, 1'b0);
    drive(k + 7, 1'b1);
    wait_neg(k + 40);
    chk("toggle_writes", 0, 64'(wcnt[0] - bw[0]), 64'd16);
    chk("toggle_done_pulses", 0, 64'(dcnt[0] - bd[0]), 64'd1);
    chk("toggle_busy_len", 0, 64'(last_run[0]), 64'd16);

    // Rising edge lands in the done cycle: back-to-back sweeps.
    drive(ecnt + 2, 1'b0);
    repeat (5) @(negedge ap_clk);
    k = ecnt + 3;
    for (int d = 0; d < ND; d++) begin bw[d] = wcnt[d]; bd[d] = dcnt[d]; end
    drive(k, 1'b1);
    drive(k + 4, 1'b0);
    drive(k + 17, 1'b1);
    wait_neg(k + 60);
    chk("retrigger_writes", 0, 64'(wcnt[0] - bw[0]), 64'd32);
    chk("retrigger_done_pulses", 0, 64'(dcnt[0] - bd[0]), 64'd2);
    chk("retrigger_second_start", 0, 64'(rise_edge[0] - k), 64'd19);

    // Asynchronous reset at address 9, then level held high: no sweep until a toggle.
    drive(ecnt + 2, 1'b0);
    repeat (5) @(negedge ap_clk);
    k = ecnt + 3;
    drive(k, 1'b1);
    wait_neg(k + 11);
    chk("pre_reset_addr", 0, 64'(a16), 64'd9);
    ap_rst_n = 1'b0;
    #1;
    chk_zero_all("async_reset_outputs");
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int d = 0; d < ND; d++) bw[d] = wcnt[d];
    wait_neg(ecnt + 40);
    for (int d = 0; d < ND; d++) chk("no_sweep_after_reset", d, 64'(wcnt[d] - bw[d]), 64'd0);
    k = ecnt + 2;
    bw[0] = wcnt[0];
    drive(k, 1'b0);
    drive(k + 3, 1'b1);
    wait_neg(k + 40);
    chk("sweep_after_toggle", 0, 64'(wcnt[0] - bw[0]), 64'd16);

    // Full-depth sweep on the 1024-word instance.
    clear_req = 1'b0;
    ap_rst_n  = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (4) @(negedge ap_clk);
    k = ecnt + 2;
    for (int d = 0; d < ND; d++) begin bw[d] = wcnt[d]; bd[d] = dcnt[d]; end
    drive(k, 1'b1);
    wait_neg(k + 1040);
    chk("full_writes", 1, 64'(wcnt[1] - bw[1]), 64'd1024);
    chk("full_last_addr", 1, 64'(last_addr[1]), 64'h3FF);
    chk("full_busy_len", 1, 64'(last_run[1]), 64'd1024);
    chk("full_done_pulses", 1, 64'(dcnt[1] - bd[1]), 64'd1);
    chk("full_latency", 1, 64'(rise_edge[1] - k), 64'd2);

    // Fill word captured at start and held while the source changes mid-sweep.
    drive(ecnt + 2, 1'b0);
    repeat (5) @(negedge ap_clk);
`ifdef BRAM_CLEAR_FILL_EN
    fill_value = 32'hDEADBEEF;
`endif
    k = ecnt + 2;
    drive(k, 1'b1);
    wait_neg(k + 8);
`ifdef BRAM_CLEAR_FILL_EN
    fill_value = 32'h0;
`endif
    wait_neg(k + 40);
    for (int a = 0; a < 16; a++) begin
      chk("fill_mem_data", 0, 64'(mem[0][a]), 64'(FILL_EXP));
      chk("fill_mem_written", 0, 64'(wr_edge[0][a] >= k), 64'd1);
    end

    // Randomised request levels with occasional resets, checked by the model every cycle.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        ap_rst_n = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge ap_clk);
        ap_rst_n = 1'b1;
      end else begin
        clear_req = ~clear_req;
      end
`ifdef BRAM_CLEAR_FILL_EN
      fill_value = $urandom;
`endif
      repeat ($urandom_range(1, 24)) @(negedge ap_clk);
    end
    clear_req = 1'b0;
    repeat (20) @(negedge ap_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
